mr_fetch_unit: RTL

- Instruction fetch/prefetch stage directly upstream of the mr_chips decode/execute core.
- Issues word-addressed requests to instruction memory and buffers returned 16-bit instructions with their PCs in a small FIFO.
- Presents buffered instructions to the core through a valid/ready handshake.
- Flushes and restarts on a branch/jump redirect from the core.

---
 rtl/mr_chips_pkg.sv | 18 +
 rtl/mr_fetch_fifo.sv | 77 +++++++
 rtl/mr_fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mr_chips_pkg.sv
// Shared definitions for the mr_chips fetch stage and core.
//   fetch_state_e : fetch FSM states (IDLE, FETCH, DRAIN)
//   MR_ADDR_W     : instruction word-address width
//   MR_DATA_W     : instruction width
//   MR_RESET_PC   : default first fetch address after reset
package mr_chips_pkg;

    localparam int unsigned MR_ADDR_W = 16;
    localparam int unsigned MR_DATA_W = 16;
    localparam logic [MR_ADDR_W-1:0] MR_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/mr_fetch_fifo.sv
// Synchronous instruction FIFO holding {pc, data} entries.
// Ports:
//   clk, reset            : clock, async active-low reset
//   push, push_pc/data    : write an entry at the tail
//   pop                   : drop the head entry (ignored when empty)
//   flush                 : discard all entries (wins over push/pop)
//   head_pc, head_data    : head entry, combinational from storage
//   count, full, empty    : occupancy status
module mr_fetch_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = mr_chips_pkg::MR_ADDR_W,
    parameter int unsigned DATA_W = mr_chips_pkg::MR_DATA_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_q;
    logic [PTR_W-1:0]  wr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_pop;

    assign do_pop    = pop && !empty;
    assign head_pc   = mem_q[rd_q].pc;
    assign head_data = mem_q[rd_q].data;
    assign count     = cnt_q;
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= '{pc: push_pc, data: push_data};
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mr_fetch_unit.sv
// Instruction fetch/prefetch stage feeding the mr_chips core.
// Ports:
//   clk, reset                       : clock, async active-low reset
//   imem_req/addr/gnt                : request channel to instruction memory
//   imem_rvalid/rdata                : in-order response channel
//   redirect_valid/pc                : fetch restart from the core
//   inst_valid/ready/data/pc         : buffered instruction handshake to the core
//   pc_out                           : next address to be requested
module mr_fetch_unit
    import mr_chips_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = mr_chips_pkg::MR_ADDR_W,
    parameter int unsigned       DATA_W   = mr_chips_pkg::MR_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = mr_chips_pkg::MR_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  disc_q, disc_d;
    logic              seen_gnt_q;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OCC_W-1:0]  occupancy;
    logic              grant;
    logic              rsp_fetch;
    logic              push;
    logic              pop;
    logic              flush;
    logic [ADDR_W-1:0] rsp_pc;

    assign occupancy = {1'b0, fifo_count} + {1'b0, outst_q};
    assign imem_req  = (state_q == FETCH) && (occupancy < OCC_W'(DEPTH)) && !redirect_valid;
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign grant     = imem_req && imem_gnt;

    // Responses with nothing outstanding are protocol errors and are ignored.
    assign rsp_fetch = imem_rvalid && (state_q == FETCH) && (outst_q != '0);
    assign push      = rsp_fetch && !redirect_valid;
    assign inst_valid = !fifo_empty;
    assign pop       = inst_valid && inst_ready;
    assign flush     = redirect_valid && (state_q != IDLE);

    // Requests are sequential from pc_q, so the oldest outstanding one is pc_q - outst_q.
    assign rsp_pc = pc_q - ADDR_W'(outst_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        outst_d = outst_q;
        disc_d  = disc_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                outst_d = outst_q + CNT_W'(grant) - CNT_W'(rsp_fetch);
                if (grant) begin
                    pc_d = pc_q + ADDR_W'(1);
                end
                if (redirect_valid) begin
                    // Everything still in flight belongs to the old stream.
                    pc_d    = redirect_pc;
                    disc_d  = outst_d;
                    outst_d = '0;
                    if (disc_d != '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (imem_rvalid && (disc_q != '0)) begin
                    disc_d = disc_q - CNT_W'(1);
                end
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (disc_d == '0) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            outst_q    <= '0;
            disc_q     <= '0;
            seen_gnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            outst_q    <= outst_d;
            disc_q     <= disc_d;
            seen_gnt_q <= seen_gnt_q | grant;
            assert (!(push && fifo_full && !pop));
            // Stale responses before the first grant after reset are legal and ignored.
            assert (!(imem_rvalid && seen_gnt_q && (outst_q == '0) && (disc_q == '0)));
        end
    end

    mr_fetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_pc   (rsp_pc),
        .push_data (imem_rdata),
        .pop       (pop),
        .flush     (flush),
        .head_pc   (inst_pc),
        .head_data (inst_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
